// File: rtl/load_result_unit.sv
// Load result unit: takes AGU load uops, issues word reads, tracks DEPTH
// in-flight loads in order and aligns/extends returned data for writeback.
module load_result_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IN_valid,
  output logic        OUT_ready,
  input  logic [31:0] IN_addr,
  input  logic [1:0]  IN_size,
  input  logic        IN_signExt,
  input  logic        IN_exception,
  input  logic [6:0]  IN_tagDst,
  input  logic [4:0]  IN_nmDst,
  input  logic [6:0]  IN_sqN,
  input  logic        IN_branchTaken,
  input  logic [6:0]  IN_branchSqN,
  output logic        OUT_memReq,
  output logic [29:0] OUT_memAddr,
  input  logic        IN_memGrant,
  input  logic        IN_memRValid,
  input  logic [31:0] IN_memRData,
  output logic        OUT_valid,
  input  logic        IN_wbStall,
  output logic [31:0] OUT_result,
  output logic [6:0]  OUT_tagDst,
  output logic [4:0]  OUT_nmDst,
  output logic [6:0]  OUT_sqN,
  output logic        OUT_exception
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sext;
    logic        exc;
    logic [6:0]  tag;
    logic [4:0]  nm;
    logic [6:0]  sqn;
  } req_t;

  typedef struct packed {
    logic [6:0]  tag;
    logic [4:0]  nm;
    logic [6:0]  sqn;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        sext;
    logic        exc;
    logic        no_mem;
    logic        killed;
    logic        dvalid;
    logic [31:0] data;
  } ent_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [6:0]  tag;
    logic [4:0]  nm;
    logic [6:0]  sqn;
    logic        exc;
  } out_t;

  // Strictly younger than the branch in the wrapping 7-bit sequence space.
  function automatic logic younger(input logic [6:0] sqn, input logic [6:0] br);
    logic [6:0] d;
    d = sqn - br;
    return !d[6] && (d != 7'd0);
  endfunction

  req_t          req_q, req_d;
  ent_t          ent_q [DEPTH];
  ent_t          ent_d [DEPTH];
  out_t          out_q, out_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   cnt_q, cnt_d;

  logic          not_full, req_move, accept, rsp_hit, pop, head_kill;
  logic [PW-1:0] rsp_idx;
  ent_t          hd;
  logic [31:0]   w, res;

  always_comb begin
    not_full    = cnt_q != (PW+1)'(DEPTH);
    req_move    = req_q.valid && not_full && (req_q.exc || IN_memGrant);
    OUT_memReq  = req_q.valid && !req_q.exc && not_full;
    OUT_ready   = !req_q.valid || req_move;
    OUT_memAddr = req_q.addr[31:2];
    accept      = IN_valid && OUT_ready && !(IN_branchTaken && younger(IN_sqN, IN_branchSqN));
  end

  // Oldest entry still owed memory data; responses come back in grant order.
  always_comb begin
    rsp_hit = 1'b0;
    rsp_idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rsp_hit && (PW+1)'(i) < cnt_q && !ent_q[head_q + PW'(i)].no_mem &&
          !ent_q[head_q + PW'(i)].dvalid) begin
        rsp_hit = 1'b1;
        rsp_idx = head_q + PW'(i);
      end
    end
  end

  always_comb begin
    hd        = ent_q[head_q];
    head_kill = hd.killed || (IN_branchTaken && younger(hd.sqn, IN_branchSqN));
    pop       = (cnt_q != '0) && (hd.dvalid || hd.no_mem) &&
                (head_kill || !out_q.valid || !IN_wbStall);
    w = hd.data >> {hd.off, 3'b000};
    case (hd.size)
      2'd0:    res = {{24{hd.sext & w[7]}}, w[7:0]};
      2'd1:    res = {{16{hd.sext & w[15]}}, w[15:0]};
      default: res = w;
    endcase
    if (hd.exc) res = '0;
  end

  always_comb begin
    req_d = req_q;
    if (req_move || (IN_branchTaken && younger(req_q.sqn, IN_branchSqN))) req_d.valid = 1'b0;
    if (accept)
      req_d = '{valid: 1'b1, addr: IN_addr, size: IN_size, sext: IN_signExt, exc: IN_exception,
                tag: IN_tagDst, nm: IN_nmDst, sqn: IN_sqN};

    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++)
      if (IN_branchTaken && younger(ent_q[i].sqn, IN_branchSqN)) ent_d[i].killed = 1'b1;
    // Killed entries still take their response so later data lines up.
    if (IN_memRValid && rsp_hit) begin
      ent_d[rsp_idx].dvalid = 1'b1;
      ent_d[rsp_idx].data   = IN_memRData;
    end
    if (req_move)
      ent_d[tail_q] = '{tag: req_q.tag, nm: req_q.nm, sqn: req_q.sqn, off: req_q.addr[1:0],
                        size: req_q.size, sext: req_q.sext, exc: req_q.exc, no_mem: req_q.exc,
                        killed: IN_branchTaken && younger(req_q.sqn, IN_branchSqN),
                        dvalid: 1'b0, data: '0};

    head_d = pop ? head_q + PW'(1) : head_q;
    tail_d = req_move ? tail_q + PW'(1) : tail_q;
    cnt_d  = cnt_q + (PW+1)'(req_move) - (PW+1)'(pop);

    out_d = out_q;
    if (!IN_wbStall || (IN_branchTaken && younger(out_q.sqn, IN_branchSqN))) out_d.valid = 1'b0;
    if (pop && !head_kill)
      out_d = '{valid: 1'b1, result: res, tag: hd.tag, nm: hd.nm, sqn: hd.sqn, exc: hd.exc};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q  <= '0;
      out_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      req_q  <= req_d;
      out_q  <= out_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ent_q  <= ent_d;
    end
  end

  assign OUT_valid     = out_q.valid;
  assign OUT_result    = out_q.result;
  assign OUT_tagDst    = out_q.tag;
  assign OUT_nmDst     = out_q.nm;
  assign OUT_sqN       = out_q.sqn;
  assign OUT_exception = out_q.exc;
endmodule
